// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD encoder (shift-add-3), one input bit per clock.
// Start/busy/done handshake; the last result is held on bcd/ovf between conversions.
module bin_to_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic longint unsigned max_val();
    longint unsigned p = 1;
    for (int unsigned i = 0; i < DIGITS; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam longint unsigned MAXV = max_val();

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]   acc;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   acc_next;
  logic [CW-1:0]   cnt;
  logic            ovf_pending;

  // Per-nibble add-3 with no carry between nibbles, then one shift step.
  always_comb begin
    adj = acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    acc_next = {adj[BW-2:0], sreg[WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      ovf         <= 1'b0;
      cnt         <= '0;
      sreg        <= '0;
      acc         <= '0;
      ovf_pending <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg        <= bin;
            acc         <= '0;
            cnt         <= '0;
            ovf_pending <= (64'(bin) > MAXV);
            busy        <= 1'b1;
            state       <= CONV;
          end
        end
        CONV: begin
          acc  <= acc_next;
          sreg <= sreg << 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bcd   <= ovf_pending ? {DIGITS{4'h9}} : acc_next;
            ovf   <= ovf_pending;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Bench for bin_to_bcd: directed and random conversions on 8-bit and 10-bit instances,
// checked against a decimal-arithmetic reference.
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start10;
  logic [7:0]  bin8;
  logic [9:0]  bin10;
  logic        busy8, done8, ovf8, busy10, done10, ovf10;
  logic [11:0] bcd8, bcd10;

  always #5 clk = ~clk;

  bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8)
  );

  bin_to_bcd #(.WIDTH(10), .DIGITS(3)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .bin(bin10),
    .busy(busy10), .done(done10), .bcd(bcd10), .ovf(ovf10)
  );

  logic        sel;
  logic        busy_s, done_s, ovf_s;
  logic [11:0] bcd_s;
  assign busy_s = sel ? busy10 : busy8;
  assign done_s = sel ? done10 : done8;
  assign ovf_s  = sel ? ovf10  : ovf8;
  assign bcd_s  = sel ? bcd10  : bcd8;

  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: saturate at 999, then split into decimal digits.
  function automatic logic [11:0] ref_bcd(input int v);
    int s;
    s = (v > 999) ? 999 : v;
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic drive_start(input logic w, input int v, input logic s);
    if (w) begin start10 = s; bin10 = 10'(v); end
    else   begin start8  = s; bin8  = 8'(v);  end
  endtask

  // One conversion; 'started' means start/bin are already applied at this negedge,
  // 'chain' re-asserts start with nv in the done cycle, 'poke' pulses start mid-run.
  task automatic conv(input logic w, input int v, input logic started,
                      input logic chain, input int nv, input int poke);
    int          wd;
    int          good;
    logic [11:0] prev;
    logic [11:0] exp;
    logic        eo;
    wd  = w ? 10 : 8;
    sel = w;
    if (!started) begin
      @(negedge clk);
      drive_start(w, v, 1'b1);
    end
    prev = bcd_s;
    @(negedge clk);
    drive_start(w, int'($urandom), 1'b0);
    good = 0;
    for (int k = 0; k < wd; k++) begin
      if (busy_s === 1'b1 && done_s === 1'b0 && bcd_s === prev) good++;
      drive_start(w, int'($urandom), (k == poke) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    eo  = (v > 999);
    exp = ref_bcd(v);
    check($sformatf("busy_window(%0d)", v), good, wd);
    check($sformatf("done(%0d)", v), done_s, 1);
    check($sformatf("busy_at_done(%0d)", v), busy_s, 0);
    check($sformatf("bcd(%0d)", v), bcd_s, exp);
    check($sformatf("ovf(%0d)", v), ovf_s, eo);
    if (chain) drive_start(w, nv, 1'b1);
    else begin
      @(negedge clk);
      check($sformatf("done_pulse(%0d)", v), done_s, 0);
      check($sformatf("bcd_hold(%0d)", v), bcd_s, exp);
    end
  endtask

  initial begin
    int nd;
    sel = 1'b0;
    rst = 1'b1;
    start8 = 1'b1; bin8 = 8'd55;
    start10 = 1'b1; bin10 = 10'd55;
    repeat (3) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_bcd8", bcd8, 0);
    check("rst_ovf8", ovf8, 0);
    check("rst_busy10", busy10, 0);
    check("rst_bcd10", bcd10, 0);
    rst = 1'b0; start8 = 1'b0; start10 = 1'b0;

    // Basic values and nibble-boundary cases.
    conv(1'b0, 0,   1'b0, 1'b0, 0, -1);
    conv(1'b0, 255, 1'b0, 1'b0, 0, -1);
    conv(1'b0, 99,  1'b0, 1'b0, 0, -1);
    conv(1'b0, 100, 1'b0, 1'b0, 0, -1);
    conv(1'b0, 9,   1'b0, 1'b0, 0, -1);

    // Back-to-back: start held during the done cycle.
    conv(1'b0, 128, 1'b0, 1'b1, 7, -1);
    conv(1'b0, 7,   1'b1, 1'b0, 0, -1);

    // Start pulsed mid-conversion is ignored.
    conv(1'b0, 37,  1'b0, 1'b0, 0, 3);

    // Reset during conversion aborts it.
    sel = 1'b0;
    @(negedge clk); drive_start(1'b0, 200, 1'b1);
    @(negedge clk); drive_start(1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_bcd", bcd8, 0);
    check("abort_ovf", ovf8, 0);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8 !== 1'b0 || busy8 !== 1'b0) nd++;
      @(negedge clk);
    end
    check("abort_quiet", nd, 0);
    conv(1'b0, 200, 1'b0, 1'b0, 0, -1);

    // 10-bit instance: saturation boundary.
    conv(1'b1, 999,  1'b0, 1'b0, 0, -1);
    conv(1'b1, 1000, 1'b0, 1'b0, 0, -1);
    conv(1'b1, 1023, 1'b0, 1'b0, 0, -1);
    conv(1'b1, 5,    1'b0, 1'b0, 0, -1);

    // Random values on both instances.
    for (int i = 0; i < 12; i++) conv(1'b0, int'($urandom_range(0, 255)), 1'b0, 1'b0, 0, -1);
    for (int i = 0; i < 12; i++) conv(1'b1, int'($urandom_range(0, 1023)), 1'b0, 1'b0, 0, -1);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
